// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: instruction input side and immediate result side.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    // master: the environment feeding instructions and consuming results
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    // slave: the immediate-generator stage itself
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// RISC-V immediate generator: opcode decode and sign-extension to XLEN,
// registered behind a two-entry skid buffer so backpressure never stalls throughput.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    imm_gen_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    logic [31:0]     instr;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    logic            main_valid;
    logic [XLEN-1:0] main_imm;
    fmt_t            main_fmt;
    logic            main_illegal;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    fmt_t            skid_fmt;
    logic            skid_illegal;

    logic            accept;
    logic            pop;

    assign instr = bus.in_instr;

    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b1;
        case (instr[6:0])
            7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec_fmt     = FMT_I;
                dec_illegal = 1'b0;
            end
            7'b0100011: begin
                dec_fmt     = FMT_S;
                dec_illegal = 1'b0;
            end
            7'b1100011: begin
                dec_fmt     = FMT_B;
                dec_illegal = 1'b0;
            end
            7'b0010111, 7'b0110111: begin
                dec_fmt     = FMT_U;
                dec_illegal = 1'b0;
            end
            7'b1101111: begin
                dec_fmt     = FMT_J;
                dec_illegal = 1'b0;
            end
            7'b0110011: begin
                dec_fmt     = FMT_R;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Every format is first sign-extended to 32 bits; the final cast widens to XLEN.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    assign accept = bus.in_valid & ~skid_valid;
    assign pop    = main_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid   <= 1'b0;
            main_imm     <= '0;
            main_fmt     <= FMT_NONE;
            main_illegal <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
        end else if (pop && skid_valid) begin
            // in_ready is low while the skid is full, so no accept can collide here
            main_valid   <= 1'b1;
            main_imm     <= skid_imm;
            main_fmt     <= skid_fmt;
            main_illegal <= skid_illegal;
            skid_valid   <= 1'b0;
        end else if (!main_valid || pop) begin
            main_valid <= accept;
            if (accept) begin
                main_imm     <= dec_imm;
                main_fmt     <= dec_fmt;
                main_illegal <= dec_illegal;
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
        end
    end

    assign bus.in_ready    = ~skid_valid;
    assign bus.out_valid   = main_valid;
    assign bus.out_imm     = main_imm;
    assign bus.out_fmt     = main_fmt;
    assign bus.out_illegal = main_illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_gen_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    int unsigned checks;
    int unsigned errors;

    logic [31:0] v_instr [10];
    logic [63:0] v_imm   [10];
    logic [2:0]  v_fmt   [10];
    logic        v_ill   [10];

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int idx);
        check({tag, "_valid32"}, 64'(b32.out_valid), 64'd1);
        check({tag, "_valid64"}, 64'(b64.out_valid), 64'd1);
        check({tag, "_imm32"}, {32'b0, b32.out_imm}, {32'b0, v_imm[idx][31:0]});
        check({tag, "_imm64"}, b64.out_imm, v_imm[idx]);
        check({tag, "_fmt32"}, 64'(b32.out_fmt), 64'(v_fmt[idx]));
        check({tag, "_fmt64"}, 64'(b64.out_fmt), 64'(v_fmt[idx]));
        check({tag, "_ill32"}, 64'(b32.out_illegal), 64'(v_ill[idx]));
        check({tag, "_ill64"}, 64'(b64.out_illegal), 64'(v_ill[idx]));
    endtask

    task automatic check_ready(input string tag, input logic exp);
        check({tag, "_rdy32"}, 64'(b32.in_ready), 64'(exp));
        check({tag, "_rdy64"}, 64'(b64.in_ready), 64'(exp));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid32"}, 64'(b32.out_valid), 64'd0);
        check({tag, "_valid64"}, 64'(b64.out_valid), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_idle(tag);
        check({tag, "_imm32"}, {32'b0, b32.out_imm}, 64'd0);
        check({tag, "_imm64"}, b64.out_imm, 64'd0);
        check({tag, "_fmt32"}, 64'(b32.out_fmt), 64'd7);
        check({tag, "_fmt64"}, 64'(b64.out_fmt), 64'd7);
        check({tag, "_ill32"}, 64'(b32.out_illegal), 64'd0);
        check({tag, "_ill64"}, 64'(b64.out_illegal), 64'd0);
        check_ready(tag, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        v_instr[0] = 32'hFFF00093; v_imm[0] = 64'hFFFFFFFF_FFFFFFFF; v_fmt[0] = 3'd1; v_ill[0] = 1'b0;
        v_instr[1] = 32'hFE112E23; v_imm[1] = 64'hFFFFFFFF_FFFFFFFC; v_fmt[1] = 3'd2; v_ill[1] = 1'b0;
        v_instr[2] = 32'hFE000CE3; v_imm[2] = 64'hFFFFFFFF_FFFFFFF8; v_fmt[2] = 3'd3; v_ill[2] = 1'b0;
        v_instr[3] = 32'h001000EF; v_imm[3] = 64'h00000000_00000800; v_fmt[3] = 3'd5; v_ill[3] = 1'b0;
        v_instr[4] = 32'h800000B7; v_imm[4] = 64'hFFFFFFFF_80000000; v_fmt[4] = 3'd4; v_ill[4] = 1'b0;
        v_instr[5] = 32'h0000007F; v_imm[5] = 64'h00000000_00000000; v_fmt[5] = 3'd7; v_ill[5] = 1'b1;
        v_instr[6] = 32'h002081B3; v_imm[6] = 64'h00000000_00000000; v_fmt[6] = 3'd0; v_ill[6] = 1'b0;
        v_instr[7] = 32'h12345097; v_imm[7] = 64'h00000000_12345000; v_fmt[7] = 3'd4; v_ill[7] = 1'b0;
        v_instr[8] = 32'h7FF00093; v_imm[8] = 64'h00000000_000007FF; v_fmt[8] = 3'd1; v_ill[8] = 1'b0;
        v_instr[9] = 32'h4030D093; v_imm[9] = 64'h00000000_00000403; v_fmt[9] = 3'd1; v_ill[9] = 1'b0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Streaming at full rate: result k appears the cycle after its accept.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_idle("stream_pre");
            end else begin
                check_out($sformatf("stream%0d", k - 1), k - 1);
                check_ready($sformatf("stream%0d", k - 1), 1'b1);
            end
            if (k < 10) begin
                in_valid = 1'b1;
                in_instr = v_instr[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("stream_drained");

        // Backpressure: only two accepted, output held, then drained in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = v_instr[0];
        @(negedge clk);
        check_out("bp_first", 0);
        check_ready("bp_first", 1'b1);
        in_instr = v_instr[1];
        @(negedge clk);
        check_out("bp_second", 0);
        check_ready("bp_second", 1'b0);
        in_instr = v_instr[2];
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_out($sformatf("bp_hold%0d", c), 0);
            check_ready($sformatf("bp_hold%0d", c), 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_drain1", 1);
        check_ready("bp_drain1", 1'b1);
        for (int k = 2; k < 6; k++) begin
            in_instr = v_instr[k];
            @(negedge clk);
            check_out($sformatf("bp_drain%0d", k), k);
            check_ready($sformatf("bp_drain%0d", k), 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("bp_empty");

        // Reset with both entries full discards them at once.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = v_instr[6];
        @(negedge clk);
        in_instr = v_instr[7];
        @(negedge clk);
        check_ready("rst_full", 1'b0);
        check_out("rst_full", 6);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = v_instr[3];
        @(negedge clk);
        check_out("rst_after", 3);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("rst_after_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
